// File: rtl/ahb_bus_pkg.sv
// Shared types and helpers for the parametrised M-master / S-slave request/grant bus.
package ahb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    RESP
  } bus_state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  // Index width for n items; never below 1 so single-entry vectors still get a bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Round-robin arbiter: search starts at the internal pointer, which moves past each winner.
module ahb_rr_arbiter
  import ahb_bus_pkg::*;
#(
  parameter  int NUM_M = 2,
  localparam int IDX_W = idx_width(NUM_M)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NUM_M-1:0] req_i,
  input  logic             enable_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_M; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_M) idx = idx - NUM_M;
      if (!valid_o && req_i[IDX_W'(idx)]) begin
        valid_o  = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (enable_i && valid_o)
      ptr_d = (int'(winner_o) == NUM_M - 1) ? '0 : winner_o + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ahb_bus_mxn.sv
// Single shared request/grant bus, NUM_M masters to NUM_S slaves, one transaction in flight.
// Optional response watchdog enabled by defining AHB_BUS_TIMEOUT_EN.
module ahb_bus_mxn
  import ahb_bus_pkg::*;
#(
  parameter int                          NUM_M          = 2,
  parameter int                          NUM_S          = 3,
  parameter int                          ADDR_WIDTH     = 32,
  parameter int                          DATA_WIDTH     = 32,
  parameter logic [NUM_S*ADDR_WIDTH-1:0] S_BASE         = '0,
  parameter logic [NUM_S*ADDR_WIDTH-1:0] S_MASK         = '0,
  parameter logic [DATA_WIDTH-1:0]       ERR_RDATA      = DATA_WIDTH'(ERR_RDATA_DEFAULT),
  parameter int                          TIMEOUT_CYCLES = 256
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [NUM_M-1:0]               HBUSREQ_M,
  input  logic [NUM_M*ADDR_WIDTH-1:0]    HADDR_M,
  input  logic [NUM_M-1:0]               HWRITE_M,
  input  logic [NUM_M*DATA_WIDTH/8-1:0]  HBE_M,
  input  logic [NUM_M*DATA_WIDTH-1:0]    HWDATA_M,
  output logic [NUM_M-1:0]               HGRANT_M,
  output logic [NUM_M-1:0]               HREADY_M,
  output logic [DATA_WIDTH-1:0]          HRDATA_M,
  output logic                           HERR_M,
  output logic [NUM_S-1:0]               HSEL_S,
  output logic [ADDR_WIDTH-1:0]          HADDR_S,
  output logic                           HWRITE_S,
  output logic [DATA_WIDTH/8-1:0]        HBE_S,
  output logic [DATA_WIDTH-1:0]          HWDATA_S,
  input  logic [NUM_S-1:0]               HREADY_S,
  input  logic [NUM_S*DATA_WIDTH-1:0]    HRDATA_S
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int M_W  = idx_width(NUM_M);
  localparam int S_W  = idx_width(NUM_S);

  bus_state_t            state_q, state_d;
  logic [M_W-1:0]        gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

`ifdef AHB_BUS_TIMEOUT_EN
  localparam int CNT_W = idx_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic           arb_en, arb_valid;
  logic [M_W-1:0] arb_winner;

  assign arb_en = (state_q == IDLE) || (state_q == RESP);

  ahb_rr_arbiter #(.NUM_M(NUM_M)) u_arb (
    .clk_i    (HCLK),
    .rst_i    (HRESET),
    .req_i    (HBUSREQ_M),
    .enable_i (arb_en),
    .winner_o (arb_winner),
    .valid_o  (arb_valid)
  );

  // Descending scan so the lowest-index hit is the one left standing.
  logic           hit;
  logic [S_W-1:0] sel_idx;

  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if ((addr_q & S_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == S_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        sel_idx = S_W'(i);
      end
    end
  end

  logic                  slv_ready;
  logic [DATA_WIDTH-1:0] slv_rdata;

  assign slv_ready = hit && HREADY_S[sel_idx];
  assign slv_rdata = HRDATA_S[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef AHB_BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE, RESP: begin
        if (arb_valid) begin
          state_d = ADDR;
          gnt_d   = arb_winner;
          addr_d  = HADDR_M[int'(arb_winner)*ADDR_WIDTH +: ADDR_WIDTH];
          write_d = HWRITE_M[arb_winner];
          be_d    = HBE_M[int'(arb_winner)*BE_W +: BE_W];
          wdata_d = HWDATA_M[int'(arb_winner)*DATA_WIDTH +: DATA_WIDTH];
`ifdef AHB_BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (!hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
        end else if (slv_ready) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = slv_rdata;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (slv_ready) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = slv_rdata;
        end
`ifdef AHB_BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef AHB_BUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef AHB_BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Pulses come straight from state, so reset clears them without waiting for a clock.
  always_comb begin
    HGRANT_M = '0;
    HREADY_M = '0;
    HSEL_S   = '0;
    HERR_M   = 1'b0;
    if (state_q == ADDR) begin
      HGRANT_M[gnt_q] = 1'b1;
      if (hit) HSEL_S[sel_idx] = 1'b1;
    end
    if (state_q == RESP) begin
      HREADY_M[gnt_q] = 1'b1;
      HERR_M          = err_q;
    end
  end

  assign HADDR_S  = addr_q;
  assign HWRITE_S = write_q;
  assign HBE_S    = be_q;
  assign HWDATA_S = wdata_q;
  assign HRDATA_M = rdata_q;

endmodule

// File: tb/tb_ahb_bus_mxn.sv
// Scoreboard bench for ahb_bus_mxn: 2 masters, 3 slaves, directed transactions.
module tb_ahb_bus_mxn;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam logic [NS*AW-1:0] BASE = {32'h1A20_0000, 32'h1A10_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFC0_0000};

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic [NM-1:0]    HBUSREQ_M;
  logic [NM*AW-1:0] HADDR_M;
  logic [NM-1:0]    HWRITE_M;
  logic [NM*BW-1:0] HBE_M;
  logic [NM*DW-1:0] HWDATA_M;
  logic [NM-1:0]    HGRANT_M;
  logic [NM-1:0]    HREADY_M;
  logic [DW-1:0]    HRDATA_M;
  logic             HERR_M;
  logic [NS-1:0]    HSEL_S;
  logic [AW-1:0]    HADDR_S;
  logic             HWRITE_S;
  logic [BW-1:0]    HBE_S;
  logic [DW-1:0]    HWDATA_S;
  logic [NS-1:0]    HREADY_S;
  logic [NS*DW-1:0] HRDATA_S;

  ahb_bus_mxn #(
    .NUM_M(NM), .NUM_S(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .S_BASE(BASE), .S_MASK(MASK), .ERR_RDATA(32'hDEADBEEF), .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HBUSREQ_M(HBUSREQ_M), .HADDR_M(HADDR_M), .HWRITE_M(HWRITE_M), .HBE_M(HBE_M),
    .HWDATA_M(HWDATA_M), .HGRANT_M(HGRANT_M), .HREADY_M(HREADY_M), .HRDATA_M(HRDATA_M),
    .HERR_M(HERR_M), .HSEL_S(HSEL_S), .HADDR_S(HADDR_S), .HWRITE_S(HWRITE_S),
    .HBE_S(HBE_S), .HWDATA_S(HWDATA_S), .HREADY_S(HREADY_S), .HRDATA_S(HRDATA_S)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int            m;
    logic [DW-1:0] data;
    bit            chk_data;
    bit            err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse pops the oldest expected response.
  exp_t          mon_e;
  logic [NM-1:0] mon_sel;
  always @(negedge HCLK) begin
    if (HREADY_M !== '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", HREADY_M, 0);
      end else begin
        mon_e   = sb_q.pop_front();
        mon_sel = NM'(1) << mon_e.m;
        check("resp_master", HREADY_M, mon_sel);
        check("resp_err", HERR_M, mon_e.err);
        if (mon_e.chk_data) check("resp_data", HRDATA_M, mon_e.data);
      end
    end
  end

  task automatic drive_m(input int m, input bit req, input logic [AW-1:0] addr, input bit wr,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
    HBUSREQ_M[m]         = req;
    HADDR_M[m*AW +: AW]  = addr;
    HWRITE_M[m]          = wr;
    HBE_M[m*BW +: BW]    = be;
    HWDATA_M[m*DW +: DW] = wd;
  endtask

  task automatic slave(input int s, input bit rdy, input logic [DW-1:0] d);
    HREADY_S[s]          = rdy;
    HRDATA_S[s*DW +: DW] = d;
  endtask

  task automatic push(input int m, input logic [DW-1:0] d, input bit cd, input bit err);
    exp_t e;
    e.m = m; e.data = d; e.chk_data = cd; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    HGRANT_M, 0);
    check({tag, "_hready"}, HREADY_M, 0);
    check({tag, "_hsel"},   HSEL_S,   0);
    check({tag, "_haddr"},  HADDR_S,  0);
    check({tag, "_hwrite"}, HWRITE_S, 0);
    check({tag, "_hbe"},    HBE_S,    0);
    check({tag, "_hwdata"}, HWDATA_S, 0);
    check({tag, "_hrdata"}, HRDATA_M, 0);
    check({tag, "_herr"},   HERR_M,   0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sel_cnt;
    logic [NM-1:0] exp_g;

    HRESET = 1'b1; HBUSREQ_M = '0; HADDR_M = '0; HWRITE_M = '0; HBE_M = '0;
    HWDATA_M = '0; HREADY_S = '0; HRDATA_S = '0;
    #12;
    check_all_zero("reset");
    tick();
    HRESET = 1'b0;

    // Single read, zero wait states.
    drive_m(0, 1'b1, 32'h0000_0010, 1'b0, 4'hF, 32'h0);
    slave(0, 1'b1, 32'h1234_5678);
    push(0, 32'h1234_5678, 1'b1, 1'b0);
    tick();
    check("t1_gnt", HGRANT_M, 2'b01);
    check("t1_hsel", HSEL_S, 3'b001);
    check("t1_haddr", HADDR_S, 32'h0000_0010);
    check("t1_hwrite", HWRITE_S, 0);
    drive_m(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    tick();
    check("t1_hready", HREADY_M, 2'b01);
    slave(0, 1'b0, 32'h0);

    // Write with three wait states.
    drive_m(1, 1'b1, 32'h1A10_0004, 1'b1, 4'b0001, 32'h0000_00A5);
    push(1, 32'h0, 1'b0, 1'b0);
    tick();
    check("t2_gnt", HGRANT_M, 2'b10);
    check("t2_hsel", HSEL_S, 3'b010);
    check("t2_hwdata", HWDATA_S, 32'h0000_00A5);
    check("t2_hbe", HBE_S, 4'b0001);
    check("t2_hwrite", HWRITE_S, 1);
    sel_cnt = (HSEL_S != 0) ? 1 : 0;
    drive_m(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (HSEL_S != 0) sel_cnt++;
      check($sformatf("t2_wait%0d_hready", k), HREADY_M, 0);
      if (k == 3) slave(1, 1'b1, 32'h5555_5555);
    end
    check("t2_hwdata_hold", HWDATA_S, 32'h0000_00A5);
    tick();
    check("t2_hready", HREADY_M, 2'b10);
    check("t2_hsel_cycles", sel_cnt, 1);
    slave(1, 1'b0, 32'h0);

    // Round-robin from a fresh reset, both masters requesting continuously.
    tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    drive_m(0, 1'b1, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
    drive_m(1, 1'b1, 32'h1A20_0000, 1'b0, 4'hF, 32'h0);
    slave(0, 1'b1, 32'h1111_0000);
    slave(2, 1'b1, 32'h2222_0000);
    push(0, 32'h1111_0000, 1'b1, 1'b0);
    push(1, 32'h2222_0000, 1'b1, 1'b0);
    push(0, 32'h1111_0000, 1'b1, 1'b0);
    push(1, 32'h2222_0000, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_g = (k == 1 || k == 5) ? 2'b01 : (k == 3 || k == 7) ? 2'b10 : 2'b00;
      check($sformatf("t3_gnt_c%0d", k), HGRANT_M, exp_g);
      if (k == 7) begin
        drive_m(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        drive_m(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      end
    end
    slave(0, 1'b0, 32'h0);
    slave(2, 1'b0, 32'h0);

    // Decode error: no slave matches, ready lines from all slaves ignored.
    tick();
    drive_m(0, 1'b1, 32'h8000_0000, 1'b0, 4'hF, 32'h0);
    HREADY_S = 3'b111;
    push(0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    tick();
    check("t4_gnt", HGRANT_M, 2'b01);
    check("t4_hsel_addr", HSEL_S, 3'b000);
    drive_m(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    tick();
    check("t4_hready", HREADY_M, 2'b01);
    check("t4_hsel_resp", HSEL_S, 3'b000);
    check("t4_herr", HERR_M, 1);
    check("t4_hrdata", HRDATA_M, 32'hDEAD_BEEF);
    HREADY_S = 3'b000;

    // Reset while waiting on slave 2: abandoned, no response.
    tick();
    drive_m(0, 1'b1, 32'h1A20_0010, 1'b0, 4'hF, 32'h0);
    tick();
    check("t5_gnt", HGRANT_M, 2'b01);
    check("t5_hsel", HSEL_S, 3'b100);
    drive_m(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    tick();
    tick();
    check("t5_wait_hready", HREADY_M, 0);
    #2 HRESET = 1'b1;
    #1 check_all_zero("t5_async");
    slave(2, 1'b1, 32'h3333_3333);
    tick();
    tick();
    check("t5_rst_hready", HREADY_M, 0);
    slave(2, 1'b0, 32'h0);
    HRESET = 1'b0;
    drive_m(0, 1'b1, 32'h0000_0200, 1'b0, 4'hF, 32'h0);
    drive_m(1, 1'b1, 32'h0000_0300, 1'b0, 4'hF, 32'h0);
    slave(0, 1'b1, 32'h4444_0000);
    push(0, 32'h4444_0000, 1'b1, 1'b0);
    push(1, 32'h4444_0000, 1'b1, 1'b0);
    tick();
    check("t5_first_gnt", HGRANT_M, 2'b01);
    drive_m(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    tick();
    check("t5_first_hready", HREADY_M, 2'b01);
    tick();
    check("t5_second_gnt", HGRANT_M, 2'b10);
    drive_m(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    tick();
    check("t5_second_hready", HREADY_M, 2'b10);
    slave(0, 1'b0, 32'h0);

`ifdef AHB_BUS_TIMEOUT_EN
    // Slave 1 never answers: watchdog fires after 8 WAIT cycles; a late ready is ignored.
    tick();
    drive_m(1, 1'b1, 32'h1A10_0000, 1'b0, 4'hF, 32'h0);
    push(1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    tick();
    check("t6_gnt", HGRANT_M, 2'b10);
    check("t6_hsel", HSEL_S, 3'b010);
    drive_m(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("t6_wait%0d_hready", k), HREADY_M, 0);
    end
    tick();
    check("t6_hready", HREADY_M, 2'b10);
    check("t6_herr", HERR_M, 1);
    check("t6_hrdata", HRDATA_M, 32'hDEAD_BEEF);
    slave(1, 1'b1, 32'h7777_7777);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("t6_late%0d_hready", k), HREADY_M, 0);
    end
    slave(1, 1'b0, 32'h0);
`endif

    tick();
    tick();
    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
